// File: rtl/multicycle_adder_pkg.sv
// Shared types and helpers for the multicycle adder.
package multicycle_adder_pkg;

    // Controller states: waiting, adding chunks, presenting a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the chunk index counter; a one-chunk adder still gets one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multicycle_adder_rca_chunk.sv
// CHUNK-bit combinational ripple-carry adder slice with MSB carry tap.
module rca_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb
);

    logic [W:0] ext_sum;

    // Add with one extra bit to capture the carry out of the slice.
    always_comb begin
        ext_sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        s       = ext_sum[W-1:0];
        co      = ext_sum[W];
        // The carry entering the MSB is recovered from the MSB sum equation.
        c_msb   = a[W-1] ^ b[W-1] ^ ext_sum[W-1];
    end

endmodule

// File: rtl/multicycle_adder.sv
// Multicycle adder/subtractor: processes CHUNK bits per clock, LSB chunk first.
module multicycle_adder
    import multicycle_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4   // WIDTH must be an integer multiple of CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = idx_width(N);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   x_r;
    logic [WIDTH-1:0]   y_r;       // already inverted for subtraction
    logic               carry;
    logic [IDX_W-1:0]   idx;
    logic [WIDTH-1:0]   acc;       // partial sums, kept off the s output
    logic [WIDTH-1:0]   result;
    logic               accept;
    logic               last_chunk;
    logic [CHUNK-1:0]   chunk_a;
    logic [CHUNK-1:0]   chunk_b;
    logic [CHUNK-1:0]   chunk_s;
    logic               chunk_co;
    logic               chunk_c_msb;

    // Start is honoured only when not busy; reset priority is handled in the registers.
    assign accept     = start && (state != RUN);
    assign last_chunk = (idx == IDX_W'(N - 1));
    assign chunk_a    = x_r[int'(idx) * CHUNK +: CHUNK];
    assign chunk_b    = y_r[int'(idx) * CHUNK +: CHUNK];

    rca_chunk #(
        .W(CHUNK)
    ) u_rca_chunk (
        .a    (chunk_a),
        .b    (chunk_b),
        .ci   (carry),
        .s    (chunk_s),
        .co   (chunk_co),
        .c_msb(chunk_c_msb)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_chunk) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Full-width result with the final chunk merged over the stored partial sums.
    always_comb begin
        result = acc;
        result[int'(idx) * CHUNK +: CHUNK] = chunk_s;
    end

    // Operand capture, chunk-by-chunk accumulation and result publication.
    always_ff @(posedge clk) begin
        // NOTE: every datapath register is reset so an aborted operation leaves no stale carry or index.
        if (rst) begin
            x_r   <= '0;
            y_r   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            acc   <= '0;
            s     <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            x_r   <= x;
            y_r   <= sub ? ~y : y;
            carry <= sub | c_in;   // subtraction forces the +1 of two's complement
            idx   <= '0;
        end else if (state == RUN) begin
            acc[int'(idx) * CHUNK +: CHUNK] <= chunk_s;
            carry <= chunk_co;
            idx   <= idx + 1'b1;
            if (last_chunk) begin
                s     <= result;
                c_out <= chunk_co;
                ovf   <= chunk_c_msb ^ chunk_co;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_adder.sv
// Self-checking bench for multicycle_adder (WIDTH=8, CHUNK=4).
module tb_multicycle_adder;

    typedef struct {
        logic [7:0] s;
        logic       co;
        logic       ov;
    } res_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] x;
    logic [7:0] y;
    logic       c_in;
    logic       sub;
    logic       busy;
    logic       done;
    logic [7:0] s;
    logic       c_out;
    logic       ovf;

    int         tests;
    int         fails;
    logic [7:0] last_s;

    multicycle_adder #(
        .WIDTH(8),
        .CHUNK(4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .x    (x),
        .y    (y),
        .c_in (c_in),
        .sub  (sub),
        .busy (busy),
        .done (done),
        .s    (s),
        .c_out(c_out),
        .ovf  (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: true integer arithmetic, overflow = signed result out of range.
    function automatic res_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic ci, input logic sb);
        res_t r;
        int   ua;
        int   ub;
        int   usum;
        int   sa;
        int   sbv;
        int   ssum;
        ua   = int'(a);
        ub   = sb ? (255 - int'(b)) : int'(b);
        usum = ua + ub + (sb ? 1 : int'(ci));
        sa   = (ua >= 128) ? ua - 256 : ua;
        sbv  = (int'(b) >= 128) ? int'(b) - 256 : int'(b);
        ssum = sb ? (sa - sbv) : (sa + sbv + int'(ci));
        r.s  = 8'(usum % 256);
        r.co = (usum >= 256);
        r.ov = (ssum > 127) || (ssum < -128);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: request an operation, let it be accepted, then scramble inputs.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b,
                            input logic ci, input logic sb, input string tag);
        x     = a;
        y     = b;
        c_in  = ci;
        sub   = sb;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        x     = ~a;
        y     = ~b;
        c_in  = ~ci;
        sub   = ~sb;
        check({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
        check({tag, "_done_after_accept"}, 32'(done), 32'd0);
    endtask

    // Wait (bounded) for done; expect it exactly two cycles after the accept edge.
    task automatic finish_op(input res_t exp, input int cyc0, input string tag);
        int cyc;
        bit seen;
        cyc  = cyc0;
        seen = 1'b0;
        while (!seen && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
            else check({tag, "_s_hold"}, 32'(s), 32'(last_s));
        end
        check({tag, "_latency"}, 32'(cyc), 32'd2);
        check({tag, "_s"}, 32'(s), 32'(exp.s));
        check({tag, "_c_out"}, 32'(c_out), 32'(exp.co));
        check({tag, "_ovf"}, 32'(ovf), 32'(exp.ov));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        last_s = exp.s;
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input logic sb, input string tag);
        start_op(a, b, ci, sb, tag);
        finish_op(model(a, b, ci, sb), 0, tag);
    endtask

    initial begin
        res_t e;
        tests  = 0;
        fails  = 0;
        last_s = 8'h00;
        rst    = 1'b1;
        start  = 1'b0;
        x      = 8'h00;
        y      = 8'h00;
        c_in   = 1'b0;
        sub    = 1'b0;

        // Reset state, with start asserted to confirm reset wins.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_c_out", 32'(c_out), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Directed corner values, checked against literal expectations too.
        run_op(8'hFF, 8'hFF, 1'b0, 1'b0, "add_ff_ff");
        check("add_ff_ff_lit", {23'd0, c_out, ovf, s}, {23'd0, 1'b1, 1'b0, 8'hFE});
        @(negedge clk);
        run_op(8'h0E, 8'h07, 1'b1, 1'b0, "add_cin");
        check("add_cin_lit", {23'd0, c_out, ovf, s}, {23'd0, 1'b0, 1'b0, 8'h16});
        @(negedge clk);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, "add_ovf");
        check("add_ovf_lit", {24'd0, ovf, s[7]}, {24'd0, 1'b1, 1'b1});
        @(negedge clk);
        run_op(8'h05, 8'h06, 1'b1, 1'b1, "sub_borrow");
        check("sub_borrow_lit", {23'd0, c_out, ovf, s}, {23'd0, 1'b0, 1'b0, 8'hFF});
        @(negedge clk);
        run_op(8'h80, 8'h01, 1'b0, 1'b1, "sub_ovf");
        check("sub_ovf_lit", {23'd0, c_out, ovf, s}, {23'd0, 1'b1, 1'b1, 8'h7F});
        @(negedge clk);

        // Start while busy must be ignored.
        start_op(8'h12, 8'h34, 1'b0, 1'b0, "busy_start");
        x     = 8'hAA;
        y     = 8'h55;
        c_in  = 1'b1;
        sub   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("busy_start_still_busy", 32'(busy), 32'd1);
        check("busy_start_no_done", 32'(done), 32'd0);
        finish_op(model(8'h12, 8'h34, 1'b0, 1'b0), 1, "busy_start");
        @(negedge clk);

        // Reset one cycle after accept aborts without a done pulse.
        start_op(8'h3C, 8'h4B, 1'b1, 1'b0, "abort");
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_s", 32'(s), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        last_s = 8'h00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        run_op(8'h21, 8'h43, 1'b0, 1'b0, "after_abort");

        // Start held during the done cycle: back-to-back operation.
        run_op(8'hC8, 8'h64, 1'b1, 1'b1, "b2b_second");
        run_op(8'h9A, 8'h0B, 1'b0, 1'b0, "b2b_third");
        @(negedge clk);
        check("b2b_done_drop", 32'(done), 32'd0);
        check("b2b_idle_busy", 32'(busy), 32'd0);

        // Randomized operations, some back-to-back, some with idle gaps.
        for (int i = 0; i < 24; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic       rc;
            logic       rs;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            run_op(ra, rb, rc, rs, $sformatf("rand%0d", i));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        e = model(8'h00, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        run_op(8'h00, 8'h00, 1'b0, 1'b1, "sub_zero");
        check("sub_zero_c_out", 32'(c_out), 32'(e.co));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
